// File: rtl/reg_dump_reader_pkg.sv
// Shared types and sizing rules for the register dump reader.
// Holds the FSM state encoding and the last-address rule used by the walker.
package reg_dump_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int ADDR_W_DEF   = 3;
  localparam int NUM_REGS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  // The walk ends at NUM_REGS-1, never at the top of the address space.
  function automatic int last_addr(input int num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/reg_dump_reader_if.sv
// Start/readback/stream signal bundle between the dump reader and its user.
// Stream rule: out_valid stays high and the payload is frozen until out_valid & out_ready.
interface reg_dump_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  modport slave (
    input  start, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_addr, out_last, busy, done
  );

  modport master (
    output start, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_addr, out_last, busy, done
  );

endinterface

// File: rtl/reg_dump_reader_hold.sv
// Load-enabled holding register with async active-low clear.
// Keeps the captured {last, addr, data} payload frozen while a word waits for acceptance.
module reg_dump_hold #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks register addresses 0..NUM_REGS-1 on a start pulse and streams each
// captured word out over a valid/ready handshake, pulsing done at the end.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_dump_reader_if.slave   bus,
  output state_e             state_o
);

  localparam int              LAST_ADDR = last_addr(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LAST_ADDR);
  localparam int              HOLD_W    = DATA_W + ADDR_W + 1;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;

  logic              load_d;
  logic [HOLD_W-1:0] hold_d;
  logic [HOLD_W-1:0] hold_q;

  assign load_d = (state_q == READ);
  assign hold_d = {(ptr_q == LAST_PTR), ptr_q, bus.rd_data};

  reg_dump_hold #(
    .W (HOLD_W)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load_d),
    .d_i    (hold_d),
    .q_o    (hold_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (ptr_q == LAST_PTR) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ptr_q   <= ptr_q + 1'b1;
              state_q <= READ;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // rd_addr is the only decoded output so the register file sees ptr in READ.
  assign bus.rd_addr   = ((state_q == READ) || (state_q == SEND)) ? ptr_q : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = hold_q[DATA_W-1:0];
  assign bus.out_addr  = hold_q[DATA_W +: ADDR_W];
  assign bus.out_last  = hold_q[HOLD_W-1];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: an 8-register build and a 1-register build.
// Expected words come from the register array contents in address order.
module tb_reg_dump_reader;
  import reg_dump_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_dump_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  reg_dump_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  state_e st, st1;

  reg_dump_reader #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .state_o(st)
  );
  reg_dump_reader #(.DATA_W(DW), .NUM_REGS(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .state_o(st1)
  );

  logic [DW-1:0] regs  [2**AW];
  logic [DW-1:0] regs1 [2**AW];
  assign bus.rd_data  = regs[bus.rd_addr];
  assign bus1.rd_data = regs1[bus1.rd_addr];

  int checks = 0;
  int errors = 0;

  // reference model and observed stream
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_a[$];
  bit            exp_l[$];
  logic [DW-1:0] got_d[$];
  logic [AW-1:0] got_a[$];
  bit            got_l[$];
  int n_done, stall_cycles, stable_bad, timed_out;
  int first_valid_cyc, last_acc_cyc, done_cyc;
  bit busy_at0;

  task automatic build_model();
    exp_q.delete(); exp_a.delete(); exp_l.delete();
    for (int i = 0; i < NR; i++) begin
      exp_q.push_back(regs[i]);
      exp_a.push_back(AW'(i));
      exp_l.push_back(i == NR - 1);
    end
  endtask

  // driver: start one dump and record everything the consumer sees
  task automatic run_dump(input int ready_pct, input bit spam, input int stall_addr);
    bit ready, prev_hold, seen_done, stalled_once;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    int cyc, tail, stall_left;
    got_d.delete(); got_a.delete(); got_l.delete();
    n_done = 0; stall_cycles = 0; stable_bad = 0; timed_out = 0;
    first_valid_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    ready = 0; prev_hold = 0; seen_done = 0; stalled_once = 0;
    pd = '0; pa = '0; cyc = 0; tail = 0; stall_left = 0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    busy_at0 = bus.busy;
    while (tail < 6) begin
      if (cyc > 2000) begin timed_out = 1; break; end
      if (prev_hold && (!bus.out_valid || bus.out_data !== pd || bus.out_addr !== pa))
        stable_bad++;
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.done) begin
        n_done++;
        if (!seen_done) done_cyc = cyc;
        seen_done = 1;
      end
      if (stall_addr >= 0 && !stalled_once && bus.out_valid && bus.out_addr == stall_addr[AW-1:0]) begin
        stalled_once = 1; stall_left = 5;
      end
      if (stall_left > 0) begin
        ready = 0; stall_left--; stall_cycles++;
        if (bus.rd_addr !== stall_addr[AW-1:0] || !bus.out_valid) stable_bad++;
      end else if (seen_done) ready = 1;
      else ready = ($urandom_range(99) < ready_pct);
      bus.out_ready = ready;
      if (bus.out_valid && ready) begin
        got_d.push_back(bus.out_data);
        got_a.push_back(bus.out_addr);
        got_l.push_back(bus.out_last);
        if (got_d.size() == NR) last_acc_cyc = cyc;
      end
      prev_hold = bus.out_valid && !ready;
      pd = bus.out_data; pa = bus.out_addr;
      bus.start = spam && ((bus.busy && ($urandom_range(1) == 1)) || bus.done);
      if (seen_done) tail++;
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.out_ready = 0; bus1.start = 0; bus1.out_ready = 0;
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    checks++; if (bus.out_addr !== '0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_addr_last got %h/%b want 0/0", bus.out_addr, bus.out_last); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b/%b want 0/0", bus.busy, bus.done); end
    checks++; if (bus.rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got %h want 0", bus.rd_addr); end
    checks++; if (st !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", st); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 2**AW; i++) regs[i] = DW'(16'h1000 + i);
    build_model();
    run_dump(100, 0, -1);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL seq_timeout got %0d want 0", timed_out); end
    checks++; if (busy_at0 !== 1'b1) begin errors++; $display("FAIL seq_busy got %b want 1", busy_at0); end
    checks++; if (first_valid_cyc != 1) begin errors++; $display("FAIL seq_latency got %0d want 1", first_valid_cyc); end
    checks++; if (done_cyc - last_acc_cyc != 1) begin errors++; $display("FAIL seq_done_gap got %0d want 1", done_cyc - last_acc_cyc); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL seq_done_count got %0d want 1", n_done); end
    checks++; if (got_d.size() != NR) begin errors++; $display("FAIL seq_count got %0d want %0d", got_d.size(), NR); end
    for (int i = 0; i < NR && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_q[i] || got_a[i] !== exp_a[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL seq_word%0d got %h@%0d last%b want %h@%0d last%b", i, got_d[i], got_a[i], got_l[i], exp_q[i], exp_a[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 2**AW; i++) regs[i] = DW'(16'h2000 + i);
    regs[3] = 16'hBEEF;
    build_model();
    run_dump(100, 0, 3);
    checks++; if (stall_cycles != 5) begin errors++; $display("FAIL bp_stall got %0d want 5", stall_cycles); end
    checks++; if (stable_bad != 0) begin errors++; $display("FAIL bp_stable got %0d want 0", stable_bad); end
    checks++; if (got_d.size() != NR) begin errors++; $display("FAIL bp_count got %0d want %0d", got_d.size(), NR); end
    checks++; if (got_d.size() > 3 && got_d[3] !== 16'hBEEF) begin errors++; $display("FAIL bp_word3 got %h want beef", got_d[3]); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL bp_done got %0d want 1", n_done); end
  endtask

  task automatic test_start_spam();
    for (int i = 0; i < 2**AW; i++) regs[i] = DW'($urandom);
    build_model();
    run_dump(100, 1, -1);
    checks++; if (got_d.size() != NR) begin errors++; $display("FAIL spam_count got %0d want %0d", got_d.size(), NR); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL spam_done got %0d want 1", n_done); end
    for (int i = 0; i < NR && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_q[i] || got_a[i] !== exp_a[i]) begin
        errors++; $display("FAIL spam_word%0d got %h@%0d want %h@%0d", i, got_d[i], got_a[i], exp_q[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int acc = 0;
    int cyc = 0;
    bit saw_done = 0;
    for (int i = 0; i < 2**AW; i++) regs[i] = DW'($urandom);
    bus.out_ready = 1'b1;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    while (acc < 5 && cyc < 100) begin
      @(negedge clk);
      if (bus.out_valid) acc++;
      cyc++;
    end
    checks++; if (acc != 5) begin errors++; $display("FAIL mrst_accepts got %0d want 5", acc); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_data !== '0 || bus.out_addr !== '0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL mrst_payload got %h@%0d want 0@0", bus.out_data, bus.out_addr); end
    checks++; if (bus.rd_addr !== '0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_ctrl got rd%0d busy%b v%b want 0", bus.rd_addr, bus.busy, bus.out_valid); end
    repeat (2) begin @(negedge clk); if (bus.done) saw_done = 1; end
    rst_n = 1'b1;
    @(negedge clk); if (bus.done) saw_done = 1;
    checks++; if (saw_done) begin errors++; $display("FAIL mrst_done got 1 want 0"); end
    build_model();
    run_dump(100, 0, -1);
    checks++; if (got_d.size() != NR) begin errors++; $display("FAIL mrst_count got %0d want %0d", got_d.size(), NR); end
    for (int i = 0; i < NR && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_q[i] || got_a[i] !== exp_a[i]) begin
        errors++; $display("FAIL mrst_word%0d got %h@%0d want %h@%0d", i, got_d[i], got_a[i], exp_q[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2**AW; i++) regs[i] = DW'($urandom);
      build_model();
      run_dump(50, 0, -1);
      checks++; if (timed_out != 0 || got_d.size() != NR) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", r, got_d.size(), NR); end
      checks++; if (stable_bad != 0) begin errors++; $display("FAIL rnd%0d_stable got %0d want 0", r, stable_bad); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL rnd%0d_done got %0d want 1", r, n_done); end
      for (int i = 0; i < NR && i < got_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_q[i] || got_a[i] !== exp_a[i] || got_l[i] !== exp_l[i]) begin
          errors++; $display("FAIL rnd%0d_word%0d got %h@%0d want %h@%0d", r, i, got_d[i], got_a[i], exp_q[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] v;
    for (int i = 0; i < 2**AW; i++) regs1[i] = DW'($urandom);
    v = regs1[0];
    bus1.out_ready = 1'b1;
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    @(negedge clk);
    checks++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== v) begin errors++; $display("FAIL one_word got v%b %h want v1 %h", bus1.out_valid, bus1.out_data, v); end
    checks++; if (bus1.out_addr !== '0 || bus1.out_last !== 1'b1) begin errors++; $display("FAIL one_addr_last got %0d/%b want 0/1", bus1.out_addr, bus1.out_last); end
    @(negedge clk);
    checks++; if (bus1.done !== 1'b1 || bus1.out_valid !== 1'b0) begin errors++; $display("FAIL one_done got d%b v%b want d1 v0", bus1.done, bus1.out_valid); end
    @(negedge clk);
    checks++; if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin errors++; $display("FAIL one_idle got d%b b%b want 0/0", bus1.done, bus1.busy); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_start_spam();
    test_mid_reset();
    test_random();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
